imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader and instruction memory for the Y86 pipeline.
- Write side: receives a framed program image over a valid/ready byte interface and writes it into a byte-addressed instruction memory.
- Read side: serves the fetch stage's 10-byte instruction window and supplies the start PC once loading completes.
- It is the writer for the memory the fetch stage reads.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes
ADDR_W, 10, memory index width; must equal clog2(MEM_BYTES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  producer has a byte on in_data
in_data  in  8  stream byte
in_ready  out  1  loader accepts in_data this cycle
rd_addr  in  64  fetch byte address (fPC)
rd_bytes  out  80  instruction window; rd_bytes[8*k+7:8*k] = mem[rd_addr+k], k=0..9
rd_err  out  1  rd_addr+9 >= MEM_BYTES
busy  out  1  frame in progress (state neither IDLE, DONE nor ERROR)
load_done  out  1  frame loaded and checksum good; sticky
load_err  out  1  range or checksum failure; sticky
start_pc  out  64  frame base address, zero-extended; valid when load_done=1

Behaviour:
- Single clock domain; clock port is clk.
- Reset is synchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, in_ready=1, busy=0, load_done=0, load_err=0, start_pc=0.
  - Internal counters and checksum are zeroed.
  - Memory contents are NOT reset.
- Transfer rule: a byte is consumed only on a rising edge with in_valid=1 and in_ready=1. Bubbles (in_valid=0) do not advance state.
- Frame format: 0xA5, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, CHK.
- Checksum: 8-bit sum of every byte after 0xA5, including CHK, must be 0x00.
- FSM states: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR.
  - IDLE: a byte other than 0xA5 is consumed and discarded; 0xA5 goes to ADDR_LO.
  - ADDR_LO -> ADDR_HI -> LEN_LO -> LEN_HI: fields are latched and added to the running sum.
  - LEN_HI accept: if base+LEN > MEM_BYTES (17-bit compare), go to ERROR. Else, LEN=0 goes to CHECK; otherwise go to PAYLOAD.
  - PAYLOAD: each accepted byte writes mem[base+i] at that edge, then i increments; after byte LEN-1, go to CHECK.
  - CHECK: accept CHK. Sum==0 goes to DONE (load_done=1 and start_pc=base on the cycle after the edge); otherwise go to ERROR.
  - DONE and ERROR: in_ready=0; stay there until reset.
  - Payload already written is not rolled back on error.
- in_ready is 1 in IDLE through CHECK and 0 in DONE/ERROR. It is registered, so it falls the cycle after the terminal byte.
- Read port is combinational. Same-cycle write to the read address returns the old byte; the new byte appears after the edge.
- rd_err: bytes with rd_addr+k >= MEM_BYTES read as 0x00 and rd_err=1. The check uses the full 64-bit rd_addr, so there is no wrap.
- Reset asserted mid-frame: abandons the frame and returns to IDLE; partial writes remain in memory.

Decomposition:
- Shared package y86_pkg holds:
  - FRAME_SYNC=8'hA5
  - loader state enum
  - HALT icode constant 4'h0, also used by the fetch stage
- One natural sub-module, imem_bytes: storage array with 1 write port and a 10-byte combinational read window plus range check.
- The loader FSM stays in imem_loader.

Test Plan:
1. Send A5 00 00 03 00 30 F2 0A D1 -> mem[0..2]=30 F2 0A; load_done=1, start_pc=0, load_err=0. Then rd_addr=0 -> rd_bytes[23:0]=0x0AF230, rd_err=0.
2. Send garbage 11 22, then A5 02 00 01 00 00 FD with in_valid toggling every other cycle -> garbage ignored; mem[2]=00; start_pc=2, load_done=1.
3. Send A5 00 00 01 00 10 00 (bad CHK; correct is EF) -> load_err=1, load_done=0, mem[0]=10, in_ready=0 on the following cycle.
4. Send A5 FF 03 02 00 -> ERROR after LEN_HI because 0x3FF+2 > 1024; no memory write; in_ready=0.
5. Assert rst_n=0 after 2 of 3 payload bytes -> state IDLE, in_ready=1, load_done=0; then resend frame 1 -> load completes normally.
6. rd_addr=1020 after load -> rd_err=1; rd_bytes bytes 4..9 = 00.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: frame sync byte, loader states and the HALT icode.
package y86_pkg;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;
  localparam logic [3:0] ICODE_HALT = 4'h0;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_ADDR_LO,
    LD_ADDR_HI,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_PAYLOAD,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

endpackage

// File: rtl/imem_bytes.sv
// Byte-addressed instruction store: one write port, 10-byte combinational fetch window.
module imem_bytes
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [63:0]       i_rd_addr,
  output logic [79:0]       o_rd_bytes,
  output logic              o_rd_err
);

  logic [7:0] r_mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // 65-bit sums so an address near 2^64 never wraps back into the array
  always_comb begin
    o_rd_bytes = '0;
    for (int k = 0; k < 10; k++) begin
      logic [64:0] w_a;
      w_a = {1'b0, i_rd_addr} + 65'(k);
      if (w_a < 65'(MEM_BYTES)) o_rd_bytes[8*k +: 8] = r_mem[w_a[ADDR_W-1:0]];
    end
  end

  assign o_rd_err = ({1'b0, i_rd_addr} + 65'd9) >= 65'(MEM_BYTES);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader writing the instruction memory read by fetch.
module imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [63:0] rd_addr,
  output logic [79:0] rd_bytes,
  output logic        rd_err,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic [63:0] start_pc
);

  ld_state_t   r_state;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [63:0] r_start_pc;
  logic [15:0] r_base;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [7:0]  r_sum;

  logic              w_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [15:0]       w_len_full;
  logic [16:0]       w_end;
  logic [7:0]        w_sum_nx;

  assign w_acc      = in_valid & r_ready;
  assign w_we       = w_acc && (r_state == LD_PAYLOAD);
  assign w_waddr    = r_base[ADDR_W-1:0] + r_idx[ADDR_W-1:0];
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_end      = {1'b0, r_base} + {1'b0, w_len_full};
  assign w_sum_nx   = r_sum + in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= LD_IDLE;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_start_pc <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
    end else if (w_acc) begin
      unique case (r_state)
        LD_IDLE: begin
          if (in_data == FRAME_SYNC) begin
            r_state <= LD_ADDR_LO;
            r_busy  <= 1'b1;
            r_sum   <= '0;
          end
        end
        LD_ADDR_LO: begin
          r_base[7:0] <= in_data;
          r_sum       <= w_sum_nx;
          r_state     <= LD_ADDR_HI;
        end
        LD_ADDR_HI: begin
          r_base[15:8] <= in_data;
          r_sum        <= w_sum_nx;
          r_state      <= LD_LEN_LO;
        end
        LD_LEN_LO: begin
          r_len[7:0] <= in_data;
          r_sum      <= w_sum_nx;
          r_state    <= LD_LEN_HI;
        end
        LD_LEN_HI: begin
          r_len[15:8] <= in_data;
          r_sum       <= w_sum_nx;
          r_idx       <= '0;
          // Reject the whole frame before any byte lands if it would overrun memory
          if (w_end > 17'(MEM_BYTES)) begin
            r_state <= LD_ERROR;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_len_full == 16'd0) begin
            r_state <= LD_CHECK;
          end else begin
            r_state <= LD_PAYLOAD;
          end
        end
        LD_PAYLOAD: begin
          r_sum <= w_sum_nx;
          r_idx <= r_idx + 16'd1;
          if (r_idx == r_len - 16'd1) r_state <= LD_CHECK;
        end
        LD_CHECK: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          if (w_sum_nx == 8'h00) begin
            r_state    <= LD_DONE;
            r_done     <= 1'b1;
            r_start_pc <= {48'd0, r_base};
          end else begin
            r_state <= LD_ERROR;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  imem_bytes #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (in_data),
    .i_rd_addr (rd_addr),
    .o_rd_bytes(rd_bytes),
    .o_rd_err  (rd_err)
  );

  assign in_ready  = r_ready;
  assign busy      = r_busy;
  assign load_done = r_done;
  assign load_err  = r_err;
  assign start_pc  = r_start_pc;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [63:0] rd_addr = 64'd0;
  logic [79:0] rd_bytes;
  logic        rd_err;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [63:0] start_pc;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_bytes (rd_bytes),
    .rd_err   (rd_err),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err),
    .start_pc (start_pc)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  int n_tests = 0;
  int n_fail  = 0;
  int bubble_mode = 0;  // 0: back-to-back, 1: bubble before every byte, 2: random bubbles

  logic [7:0] m_mem   [MEM_BYTES];
  bit         m_known [MEM_BYTES];

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_load_done", load_done, 0);
    check_eq("rst_load_err", load_err, 0);
    check_eq("rst_start_pc", start_pc, 0);
  endtask

  task automatic check_window(input logic [63:0] a);
    rd_addr = a;
    #1;
    check_eq("rd_err", rd_err, ({1'b0, a} + 65'd9) >= 65'(MEM_BYTES));
    for (int k = 0; k < 10; k++) begin
      logic [64:0] p;
      p = {1'b0, a} + 65'(k);
      if (p >= 65'(MEM_BYTES)) check_eq("rd_byte_oob", rd_bytes[8*k +: 8], 0);
      else if (m_known[p[9:0]]) check_eq("rd_byte", rd_bytes[8*k +: 8], m_mem[p[9:0]]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (bubble_mode == 1) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end else if (bubble_mode == 2) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    check_eq("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Frame-level expectation straight from the framing rules
  task automatic model(input bq_t q, output int s, output int term, output bit exp_done,
                       output int base, output int len);
    int sum;
    s = 0;
    while (s < q.size() && q[s] != 8'hA5) s++;
    base = {q[s+2], q[s+1]};
    len  = {q[s+4], q[s+3]};
    if (base + len > MEM_BYTES) begin
      term = s + 4;
      exp_done = 1'b0;
    end else begin
      term = s + 5 + len;
      sum = 0;
      for (int i = s + 1; i <= term; i++) sum += q[i];
      exp_done = ((sum % 256) == 0);
    end
  endtask

  // n_send < 0 sends the whole frame and checks the outcome; otherwise stops early
  task automatic run_frame(input bq_t q, input int n_send);
    int s, term, base, len, limit;
    bit exp_done;
    model(q, s, term, exp_done, base, len);
    limit = (n_send < 0) ? term + 1 : n_send;
    @(negedge clk);
    for (int i = 0; i < limit; i++) begin
      send_byte(q[i]);
      if (i == s) check_eq("busy_after_sync", busy, 1);
      if (i >= s + 5 && i < term) begin
        m_mem[10'(base + i - s - 5)]   = q[i];
        m_known[10'(base + i - s - 5)] = 1'b1;
      end
    end
    if (n_send < 0) begin
      check_eq("in_ready_after", in_ready, 0);
      check_eq("busy_after", busy, 0);
      check_eq("load_done", load_done, exp_done);
      check_eq("load_err", load_err, !exp_done);
      check_eq("start_pc", start_pc, exp_done ? 64'(base) : 64'd0);
      check_window(64'(base));
      if (len > 5) check_window(64'(base + len - 5));
    end
  endtask

  task automatic build(input int base, input int len, input int ngarb, input bit bad, output bq_t q);
    int sum;
    q = {};
    for (int i = 0; i < ngarb; i++) begin
      logic [7:0] g;
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      q.push_back(g);
    end
    q.push_back(8'hA5);
    q.push_back(8'(base));
    q.push_back(8'(base >> 8));
    q.push_back(8'(len));
    q.push_back(8'(len >> 8));
    sum = base + (base >> 8) + len + (len >> 8);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      q.push_back(d);
      sum += d;
    end
    q.push_back(8'(256 - (sum % 256) + (bad ? 1 : 0)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t q;
    bq_t f1;
    for (int i = 0; i < MEM_BYTES; i++) m_known[i] = 1'b0;
    f1 = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'hD1};

    // Directed 1: basic load at address 0
    do_reset();
    bubble_mode = 0;
    run_frame(f1, -1);
    rd_addr = 64'd0;
    #1;
    check_eq("t1_window", rd_bytes[23:0], 24'h0AF230);
    check_eq("t1_rd_err", rd_err, 0);

    // Directed 2: leading garbage, alternating bubbles
    do_reset();
    bubble_mode = 1;
    q = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFD};
    run_frame(q, -1);
    check_eq("t2_start_pc", start_pc, 64'd2);

    // Directed 3: bad checksum, payload still written
    do_reset();
    bubble_mode = 0;
    q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00};
    run_frame(q, -1);
    check_eq("t3_err", load_err, 1);

    // Boundary: frame ending exactly at the last byte of memory
    do_reset();
    build(16'h3FE, 2, 0, 1'b0, q);
    run_frame(q, -1);
    check_eq("edge_done", load_done, 1);

    // Directed 4: range overrun rejected before any write
    do_reset();
    q = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00};
    run_frame(q, -1);
    check_window(64'h3FC);

    // Directed 5: reset mid-payload, then a clean reload
    do_reset();
    run_frame(f1, 7);
    do_reset();
    run_frame(f1, -1);

    // Directed 6: window crossing the top of memory and near 2^64
    check_window(64'd1020);
    check_window(64'hFFFF_FFFF_FFFF_FFFC);

    // Random frames
    for (int t = 0; t < 30; t++) begin
      int base, len, r;
      len = $urandom_range(0, 24);
      r = $urandom_range(0, 9);
      if (r < 6) base = $urandom_range(0, 1000);
      else if (r < 8) base = MEM_BYTES - len + $urandom_range(0, 2) - 1;
      else base = $urandom_range(0, 65535);
      if (base < 0) base = 0;
      bubble_mode = $urandom_range(0, 2);
      build(base, len, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), q);
      do_reset();
      run_frame(q, -1);
      check_window(64'($urandom_range(0, MEM_BYTES + 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
